// File: rtl/board_led_scanner.sv
// 4x4 multiplexed LED scanner for the Connect-4 board display.
// Drives one row at a time. Player 1 cells are shown at full brightness and
// player 2 cells at 25% duty. The winner's cells (or every cell on a draw)
// blink. Board, owner and status are captured once per frame so that a move
// cannot tear the picture mid-scan.
module board_led_scanner #(
  parameter int unsigned DWELL_CYCLES = 1024,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] gameboard,
  input  logic [15:0] player_cells,
  input  logic [1:0]  game_status,
  output logic [3:0]  row_sel,
  output logic [3:0]  col_data,
  output logic        frame_start
);

  // DWELL_CYCLES >= 4 keeps DwellW >= 2, so the phase and blanking slices below exist.
  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  localparam logic [1:0] StatusPlaying = 2'b00;
  localparam logic [1:0] StatusP1Won   = 2'b01;
  localparam logic [1:0] StatusP2Won   = 2'b10;
  localparam logic [1:0] StatusDraw    = 2'b11;

  // Scan counters
  logic [DwellW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              blink_q, blink_d;

  // Per-frame snapshot of the game state
  logic [15:0]       board_q;
  logic [15:0]       owner_q;
  logic [1:0]        status_q;

  // Registered output next-state values
  logic [3:0]        row_sel_d;
  logic [3:0]        col_data_d;
  logic              frame_start_d;

  // Decoded counter conditions
  logic              dwell_last;
  logic              row_last;
  logic              frame_last;
  logic              scan_origin;

  // Pixel helpers for the row currently being scanned
  logic [3:0]        row_occ;
  logic [3:0]        row_own;
  logic [3:0]        p1_cells;
  logic [3:0]        p2_cells;
  logic              p1_visible;
  logic              p2_visible;
  logic              phase_zero;
  logic              blank;

  // Decode the counter state used by both the counters and the outputs.
  always_comb begin
    dwell_last  = (dwell_cnt_q == DwellLast);
    row_last    = (row_idx_q == 2'd3);
    frame_last  = (frame_cnt_q == FrameLast);
    scan_origin = (dwell_cnt_q == '0) && (row_idx_q == 2'd0);
  end

  // Next state of the dwell/row/frame/blink counter chain.
  always_comb begin
    dwell_cnt_d = dwell_cnt_q + 1'b1;
    row_idx_d   = row_idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (dwell_last) begin
      dwell_cnt_d = '0;
      row_idx_d   = row_idx_q + 2'd1;
      if (row_last) begin
        if (frame_last) begin
          frame_cnt_d = '0;
          blink_d     = ~blink_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt_q <= '0;
      row_idx_q   <= 2'd0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
      row_idx_q   <= row_idx_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // Capture the game state on the first cycle of every frame only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_q  <= 16'h0000;
      owner_q  <= 16'h0000;
      status_q <= StatusPlaying;
    end else if (scan_origin) begin
      board_q  <= gameboard;
      owner_q  <= player_cells;
      status_q <= game_status;
    end
  end

  // Select the snapshot bits belonging to the current row.
  always_comb begin
    row_occ = 4'b0000;
    row_own = 4'b0000;
    unique case (row_idx_q)
      2'd0: begin
        row_occ = board_q[3:0];
        row_own = owner_q[3:0];
      end
      2'd1: begin
        row_occ = board_q[7:4];
        row_own = owner_q[7:4];
      end
      2'd2: begin
        row_occ = board_q[11:8];
        row_own = owner_q[11:8];
      end
      2'd3: begin
        row_occ = board_q[15:12];
        row_own = owner_q[15:12];
      end
      default: begin
        row_occ = 4'b0000;
        row_own = 4'b0000;
      end
    endcase
  end

  // Work out which cells of the current row light on this cycle.
  always_comb begin
    // Owner bits are masked by occupancy so stale owner data never lights a cell.
    p1_cells   = row_occ & row_own;
    p2_cells   = row_occ & ~row_own;
    phase_zero = (dwell_cnt_q[1:0] == 2'b00);
    // First two cycles of every row stay dark so the previous row cannot ghost.
    blank      = (dwell_cnt_q[DwellW-1:1] == '0);

    p1_visible = 1'b1;
    p2_visible = 1'b1;
    if (!blink_q) begin
      unique case (status_q)
        StatusP1Won: p1_visible = 1'b0;
        StatusP2Won: p2_visible = 1'b0;
        StatusDraw: begin
          p1_visible = 1'b0;
          p2_visible = 1'b0;
        end
        default: begin
          p1_visible = 1'b1;
          p2_visible = 1'b1;
        end
      endcase
    end

    if (blank) begin
      col_data_d = 4'b0000;
    end else begin
      col_data_d = (p1_cells & {4{p1_visible}})
                 | (p2_cells & {4{p2_visible & phase_zero}});
    end
  end

  // Row enable and frame marker derived from the current counter state.
  always_comb begin
    row_sel_d     = 4'b0001 << row_idx_q;
    frame_start_d = scan_origin;
  end

  // Output registers; reset drops the matrix dark immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_sel     <= 4'b0000;
      col_data    <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      row_sel     <= row_sel_d;
      col_data    <= col_data_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: doc/board_led_scanner.md
Name: board_led_scanner

Overview:
- Downstream display stage of the Connect-4 top level. Consumes the 16-cell occupancy vector (gameboard), the per-cell owner vector (player_cells) and the 2-bit game status.
- Drives a 4x4 multiplexed LED matrix through 8 pins: 4 row selects and 4 column data lines.
- Scans one row at a time. Shows player 1 cells at full brightness and player 2 cells dimmed. Blinks the winning player's cells, or all cells on a draw.
- Board and status are snapshotted once per frame, so a move landing mid-scan cannot tear the image.

Parameters:
- DWELL_CYCLES, default 1024: clock cycles spent on each row; must be >= 4 and a multiple of 4.
- BLINK_FRAMES, default 32: frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- gameboard  in  16  cell occupied flags; cell index = row*4 + col.
- player_cells  in  16  cell owner, 1 = player 1, 0 = player 2; only meaningful where gameboard = 1.
- game_status  in  2  00 playing, 01 player 1 won, 10 player 2 won, 11 draw.
- row_sel  out  4  one-hot active-high row enable; row_sel[r] drives row r.
- col_data  out  4  active-high column data for the selected row; col_data[c] is cell row*4+c.
- frame_start  out  1  one-cycle pulse on the first cycle of row 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - row_sel = 0000, col_data = 0000, frame_start = 0.
  - Internal state cleared: dwell_cnt = 0, row_idx = 0, frame_cnt = 0, blink = 0, board_q = 0, owner_q = 0, status_q = 00.
- Counters:
  - dwell_cnt counts 0 .. DWELL_CYCLES-1, then wraps to 0.
  - row_idx increments mod 4 when dwell_cnt wraps.
  - When row_idx wraps 3 -> 0, frame_cnt increments.
  - When frame_cnt reaches BLINK_FRAMES-1 and the frame ends, frame_cnt = 0 and blink toggles.
- Snapshot:
  - On every cycle where dwell_cnt = 0 and row_idx = 0, load board_q <= gameboard, owner_q <= player_cells, status_q <= game_status.
  - This includes the first cycle after reset release.
  - Input changes at any other time take effect at the next frame start only.
- Outputs are registered with 1-cycle latency from the counter state:
  - row_sel = one-hot(row_idx).
  - frame_start = 1 exactly when dwell_cnt = 0 and row_idx = 0.
- Per-cell lit rule (phase = dwell_cnt[1:0]):
  - Unoccupied cells: never lit.
  - Player 1 cells: lit on every phase.
  - Player 2 cells: lit only when phase = 00, i.e. 25% duty.
- Blanking: col_data is forced to 0000 on dwell_cnt = 0 and dwell_cnt = 1 of every row (anti-ghosting). This blanking overrides all other rules.
- Blink (uses status_q):
  - 01: player 1 cells extinguished while blink = 0.
  - 10: player 2 cells extinguished while blink = 0.
  - 11: all cells extinguished while blink = 0.
  - 00: no blinking. The blink counter still runs and is not reset by status changes.
- Boundary conditions:
  - A gameboard change on the same cycle as the snapshot is captured.
  - player_cells bits where gameboard = 0 are ignored.
  - Reset mid-row: outputs drop to 0 immediately. Scanning restarts at row 0 with a fresh snapshot on the first clock after release.

Test Plan:
- Reset then release, with DWELL_CYCLES=8, BLINK_FRAMES=2:
  - Cycle 1 after release: row_sel=0001, frame_start=1, col_data=0000.
  - row_sel becomes 0010 8 cycles later.
  - frame_start repeats every 32 cycles.
- gameboard=0x000F, player_cells=0x000F, status 00:
  - Row 0 shows col_data=1111 on dwell 2..7.
  - Rows 1-3 show 0000.
- gameboard=0x00F0, player_cells=0x0000:
  - Row 1 shows col_data=1111 only on dwell 4.
  - Row 1 shows 0000 on dwell 2, 3, 5, 6, 7.
- Change gameboard from 0x0001 to 0x0003 at row 2 mid-frame:
  - Remainder of the frame unchanged.
  - Row 0 of the next frame shows col_data=0011 on dwell 2..7.
- status=01, gameboard=0x8001, player_cells=0x0001:
  - Cell 0 dark for 2 frames, then lit for 2 frames.
  - Cell 15 (player 2) keeps its 25% pattern throughout.
  - status=11: both cells blink together.
- Assert reset for 3 cycles while on row 3:
  - row_sel and col_data are 0000 asynchronously, within the same cycle.
  - After release: row_sel=0001, frame_start=1, and a new snapshot is loaded.
